// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard scoreboard.
// Cause codes, default forwarding latencies and the scoreboard width helper.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_IFETCH,
        HZ_RAW,
        HZ_REDIRECT,
        HZ_MEM,
        HZ_RESET
    } hzd_cause_t;

    localparam int ALU_LAT_DEF  = 0;
    localparam int LOAD_LAT_DEF = 1;

    // Bits needed to hold the largest countdown value; never narrower than 1.
    function automatic int sb_width(input int alu_lat, input int load_lat);
        int m;
        int w;
        m = (alu_lat > load_lat) ? alu_lat : load_lat;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_scoreboard_unit_if #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
);
    import hazard_scoreboard_unit_pkg::*;

    localparam int RA_W = $clog2(NREG);

    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic            id_wr_en;
    logic [RA_W-1:0] id_wr_reg;
    logic            id_is_load;
    logic            ex_redirect;
    logic            ihit;
    logic            dmem_req;
    logic            dhit;

    logic             pc_enable;
    logic             en_if_id;
    logic             en_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    hzd_cause_t       hz_cause;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en,
               id_wr_reg, id_is_load, ex_redirect, ihit, dmem_req, dhit,
        input  pc_enable, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, hz_cause, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en,
               id_wr_reg, id_is_load, ex_redirect, ihit, dmem_req, dhit,
        output pc_enable, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, hz_cause, stall_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_unit_sb_regs.sv
// Per-register countdown array: nonzero entry means the result is not yet forwardable.
module hazard_sb_regs #(
    parameter int NREG = 32,
    parameter int SB_W = 1,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            advance,
    input  logic            issue,
    input  logic [RA_W-1:0] wr_reg,
    input  logic [SB_W-1:0] init_val,
    input  logic [RA_W-1:0] ra_a,
    input  logic [RA_W-1:0] ra_b,
    output logic            busy_a,
    output logic            busy_b
);

    logic [NREG-1:0][SB_W-1:0] sb;

    // Entry 0 is pinned to zero so r0 reads can index the array directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb <= '0;
        end else begin
            sb[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (issue && wr_reg == RA_W'(i))
                    sb[i] <= init_val;
                else if (advance && sb[i] != '0)
                    sb[i] <= sb[i] - SB_W'(1);
            end
        end
    end

    assign busy_a = (sb[ra_a] != '0);
    assign busy_b = (sb[ra_b] != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: RAW detection via countdown scoreboard, freeze/redirect/
// fetch-miss priority, latch enable/flush encoding and a saturating stall counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    hazard_scoreboard_unit_if.slave  hif
);

    localparam int RA_W = $clog2(NREG);
    localparam int SB_W = sb_width(ALU_LAT, LOAD_LAT);

    logic             freeze, raw, imiss, advance, issue;
    logic             busy_rs, busy_rt;
    logic [SB_W-1:0]  init_val;
    logic             pc_en;
    logic [3:0]       en;
    logic             fl_if_id, fl_id_ex;
    hzd_cause_t       cause;
    logic [CNT_W-1:0] stall_cnt;

    hazard_sb_regs #(.NREG(NREG), .SB_W(SB_W), .RA_W(RA_W)) u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .advance  (advance),
        .issue    (issue),
        .wr_reg   (hif.id_wr_reg),
        .init_val (init_val),
        .ra_a     (hif.id_rs),
        .ra_b     (hif.id_rt),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt)
    );

    assign freeze = hif.dmem_req & ~hif.dhit;
    assign imiss  = ~hif.ihit;
    // Entry 0 never holds a count, so r0 sources cannot raise a hazard.
    assign raw    = hif.id_valid & ((hif.id_uses_rs & busy_rs) | (hif.id_uses_rt & busy_rt));

    assign advance  = ~RST & ~freeze;
    assign issue    = advance & hif.id_valid & hif.id_wr_en & (hif.id_wr_reg != '0)
                    & ~hif.ex_redirect & ~raw;
    assign init_val = hif.id_is_load ? SB_W'(LOAD_LAT) : SB_W'(ALU_LAT);

    // en = {if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        pc_en    = 1'b1;
        en       = 4'b1111;
        fl_if_id = 1'b0;
        fl_id_ex = 1'b0;
        cause    = HZ_NONE;
        if (RST) begin
            pc_en    = 1'b0;
            en       = 4'b0000;
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
            cause    = HZ_RESET;
        end else if (freeze) begin
            pc_en = 1'b0;
            en    = 4'b0000;
            cause = HZ_MEM;
        end else if (hif.ex_redirect) begin
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
            cause    = HZ_REDIRECT;
        end else if (raw) begin
            pc_en    = 1'b0;
            en       = 4'b0111;
            fl_id_ex = 1'b1;
            cause    = HZ_RAW;
        end else if (imiss) begin
            pc_en    = 1'b0;
            fl_if_id = 1'b1;
            cause    = HZ_IFETCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            stall_cnt <= '0;
        else if (!pc_en && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hif.pc_enable    = pc_en;
    assign hif.en_if_id     = en[3];
    assign hif.en_id_ex     = en[2];
    assign hif.en_ex_mem    = en[1];
    assign hif.en_mem_wb    = en[0];
    assign hif.flush_if_id  = fl_if_id;
    assign hif.flush_id_ex  = fl_id_ex;
    assign hif.hz_cause     = cause;
    assign hif.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic against a
// model that tracks, per register, the advance count at which its result becomes usable.
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit       rst;
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit       we;
        bit [4:0] wr;
        bit       ld;
        bit       redir;
        bit       ihit;
        bit       dreq;
        bit       dhit;
    } stim_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    hazard_scoreboard_unit_if #(.NREG(NREG), .CNT_W(CNT_W)) hif ();

    hazard_scoreboard_unit #(.NREG(NREG), .ALU_LAT(0), .LOAD_LAT(1), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hif (hif)
    );

    int total = 0;
    int bad   = 0;

    // Model state: a register is busy while the number of ID/EX advances seen so far
    // is below the advance count recorded when its producer issued.
    int ready_at [NREG];
    int adv_n   = 0;
    int m_cnt   = 0;
    bit cnt_ok  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.ihit = 1'b1;
        return s;
    endfunction

    function automatic stim_t op(input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                                 input bit urt, input bit [4:0] wr, input bit ld);
        stim_t s;
        s = nop();
        s.v = 1'b1; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        s.we = (wr != 0) || ld; s.wr = wr; s.ld = ld;
        return s;
    endfunction

    task automatic step(input stim_t s);
        bit         frz, raw, e_pc, e_fif, e_fid, iss;
        bit [3:0]   e_en;
        hzd_cause_t e_cause;
        RST             = s.rst;
        hif.id_valid    = s.v;
        hif.id_rs       = s.rs;
        hif.id_rt       = s.rt;
        hif.id_uses_rs  = s.urs;
        hif.id_uses_rt  = s.urt;
        hif.id_wr_en    = s.we;
        hif.id_wr_reg   = s.wr;
        hif.id_is_load  = s.ld;
        hif.ex_redirect = s.redir;
        hif.ihit        = s.ihit;
        hif.dmem_req    = s.dreq;
        hif.dhit        = s.dhit;
        #4;
        frz = s.dreq && !s.dhit;
        raw = s.v && ((s.urs && s.rs != 0 && ready_at[s.rs] > adv_n) ||
                      (s.urt && s.rt != 0 && ready_at[s.rt] > adv_n));
        if (s.rst)        begin e_pc = 0; e_en = 4'b0000; e_fif = 1; e_fid = 1; e_cause = HZ_RESET;    end
        else if (frz)     begin e_pc = 0; e_en = 4'b0000; e_fif = 0; e_fid = 0; e_cause = HZ_MEM;      end
        else if (s.redir) begin e_pc = 1; e_en = 4'b1111; e_fif = 1; e_fid = 1; e_cause = HZ_REDIRECT; end
        else if (raw)     begin e_pc = 0; e_en = 4'b0111; e_fif = 0; e_fid = 1; e_cause = HZ_RAW;      end
        else if (!s.ihit) begin e_pc = 0; e_en = 4'b1111; e_fif = 1; e_fid = 0; e_cause = HZ_IFETCH;   end
        else              begin e_pc = 1; e_en = 4'b1111; e_fif = 0; e_fid = 0; e_cause = HZ_NONE;     end
        chk("pc_enable", 32'(hif.pc_enable), 32'(e_pc));
        chk("en", 32'({hif.en_if_id, hif.en_id_ex, hif.en_ex_mem, hif.en_mem_wb}), 32'(e_en));
        chk("flush", 32'({hif.flush_if_id, hif.flush_id_ex}), 32'({e_fif, e_fid}));
        chk("cause", 32'(hif.hz_cause), 32'(e_cause));
        if (cnt_ok) chk("stall_cycles", 32'(hif.stall_cycles), 32'(m_cnt));
        @(posedge CLK);
        if (s.rst) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            m_cnt  = 0;
            cnt_ok = 1;
        end else begin
            if (!e_pc && m_cnt < CMAX) m_cnt++;
            if (!frz) begin
                iss = s.v && s.we && s.wr != 0 && !s.redir && !raw;
                adv_n++;
                if (iss) ready_at[s.wr] = adv_n + (s.ld ? 1 : 0);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = nop();
        s.rst = 1'b1;
        step(s);
        step(s);
    endtask

    initial begin
        stim_t s;
        foreach (ready_at[i]) ready_at[i] = 0;

        do_reset();
        chk("reset_cnt", 32'(hif.stall_cycles), 32'd0);

        // load-use: one bubble then the consumer issues
        step(op(5'd0, 0, 5'd0, 0, 5'd2, 1));
        s = op(5'd2, 1, 5'd4, 1, 5'd3, 0);
        step(s);
        chk("t1_held_cnt", 32'(hif.stall_cycles), 32'd1);
        step(s);
        step(nop());

        // ALU chain, no stall
        do_reset();
        step(op(5'd0, 0, 5'd0, 0, 5'd5, 0));
        step(op(5'd5, 1, 5'd1, 1, 5'd6, 0));
        step(nop());
        chk("t2_no_stall", 32'(hif.stall_cycles), 32'd0);

        // freeze with a pending load consumer, then the RAW bubble
        step(op(5'd0, 0, 5'd0, 0, 5'd2, 1));
        s = op(5'd2, 1, 5'd0, 0, 5'd3, 0);
        s.dreq = 1'b1;
        repeat (3) step(s);
        s.dreq = 1'b0;
        step(s);
        chk("t3_cnt", 32'(hif.stall_cycles), 32'd4);
        step(s);

        // redirect kills the load in ID
        do_reset();
        s = op(5'd0, 0, 5'd0, 0, 5'd7, 1);
        s.redir = 1'b1;
        step(s);
        step(op(5'd7, 1, 5'd7, 1, 5'd8, 0));
        chk("t4_cnt", 32'(hif.stall_cycles), 32'd0);

        // r0 never tracked; lone fetch miss
        step(op(5'd0, 0, 5'd0, 0, 5'd0, 1));
        step(op(5'd0, 1, 5'd0, 1, 5'd9, 0));
        s = nop();
        s.ihit = 1'b0;
        step(s);
        chk("t5_cnt", 32'(hif.stall_cycles), 32'd1);

        // reset with a pending entry and mid-freeze
        step(op(5'd0, 0, 5'd0, 0, 5'd2, 1));
        s = nop();
        s.dreq = 1'b1;
        step(s);
        s.rst = 1'b1;
        step(s);
        step(op(5'd2, 1, 5'd0, 0, 5'd3, 0));
        chk("t6_after_rst", 32'(hif.stall_cycles), 32'd0);

        // saturation
        s = nop();
        s.ihit = 1'b0;
        repeat (20) step(s);
        chk("t6_sat", 32'(hif.stall_cycles), 32'(CMAX));

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 99) < 2);
            s.v     = ($urandom_range(0, 99) < 80);
            s.rs    = 5'($urandom_range(0, 7));
            s.rt    = 5'($urandom_range(0, 7));
            s.urs   = $urandom_range(0, 1) != 0;
            s.urt   = $urandom_range(0, 1) != 0;
            s.we    = ($urandom_range(0, 99) < 70);
            s.wr    = 5'($urandom_range(0, 7));
            s.ld    = $urandom_range(0, 1) != 0;
            s.redir = ($urandom_range(0, 99) < 8);
            s.ihit  = ($urandom_range(0, 99) < 85);
            s.dreq  = ($urandom_range(0, 99) < 25);
            s.dhit  = $urandom_range(0, 1) != 0;
            step(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
